serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Sequences a single instance of the team's 1-bit full_adder to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Holds the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Serves as the area-minimal adder for slow-path arithmetic; the upstream requester sees a plain request/completion interface.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- a  input  WIDTH  first operand; captured only on an accepted start.
- b  input  WIDTH  second operand; captured only on an accepted start.
- carry_in  input  1  initial carry; captured only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion strobe.
- result  output  WIDTH  sum; valid from done until the next accepted start.
- carry_out  output  1  final carry; valid with result.

Behaviour:
- Reset: the clock and reset are fixed for this block — one clock (clk); rst is synchronous and active-high.
  - On rst, state goes to IDLE.
  - busy=0, done=0, result=0, carry_out=0.
  - Internal operand registers, carry flip-flop and counter are cleared.
  - rst overrides start in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and carry_in (into the carry flip-flop), clears the counter and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle, the LSBs of the operand shift registers and the carry flip-flop drive the full_adder instance (left, right, past_carry).
  - The sum bit shifts into the result register from the MSB end, so the result is fully aligned after WIDTH shifts.
  - The carry flip-flop takes the adder's carry output.
  - The operand registers shift right by one.
  - The counter increments.
  - On the cycle the counter equals WIDTH-1, the last bit is processed and the state moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - carry_out equals the final carry; result holds the full sum.
  - Next state is IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE: operands are latched and the state moves to RUN (back-to-back operation).
- Latency: with start accepted at edge N, busy is high for cycles N+1..N+WIDTH and done is high in cycle N+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- Output stability:
  - result and carry_out are held from DONE until the next accepted start.
  - During RUN they show partial or shifting values and are not valid.
- Ignored requests: start during RUN is ignored; the operation in flight is not disturbed and no request is queued.
- Arithmetic:
  - {carry_out, result} = a + b + carry_in, modulo 2^(WIDTH+1).
  - Operands are treated as unsigned; no saturation.
- WIDTH=1: RUN lasts one cycle; behaviour equals a single registered full add.
- Reset mid-operation: rst during RUN or DONE aborts immediately; all outputs reach reset values on the following edge and no done is emitted.

Optional Feature:
- SERIAL_ADD_OVERFLOW_EN defined:
  - Adds output port overflow (1 bit).
  - The controller registers the carry into the MSB position, i.e. the past_carry used on the last RUN bit.
  - overflow = that carry XOR final carry_out (two's-complement signed overflow).
  - Valid and held under the same rules as result; reset value 0.
- Macro undefined:
  - The overflow port and its register do not exist.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, carry_in=0, start pulse at edge N:
  - busy=1 for cycles N+1..N+8.
  - done=1 only in cycle N+9.
  - result=0x96, carry_out=0.
- a=0xFF, b=0x01, carry_in=0 -> result=0x00, carry_out=1. Then a=0xFF, b=0xFF, carry_in=1 issued in the DONE cycle -> accepted back-to-back; result=0xFF, carry_out=1, with done 9 cycles later.
- Ignored start: start a=0x01, b=0x02, then pulse start with a=0xF0, b=0x0F at the third RUN cycle -> ignored; result=0x03 at done; exactly one done pulse.
- Mid-operation reset: start a=0xAA, b=0x55; assert rst in the fourth RUN cycle -> next cycle busy=0, done=0, result=0x00, carry_out=0. No done follows, and a new start then works normally.
- With SERIAL_ADD_OVERFLOW_EN:
  - 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
  - 0x80+0x80 -> result=0x00, carry_out=1, overflow=1.
  - 0x40+0x20 -> overflow=0.
- WIDTH=1 build: a=1, b=1, carry_in=1 -> busy for 1 cycle, done next cycle, result=1, carry_out=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose:
//    Bit-serial WIDTH-bit adder. One full_adder is reused across WIDTH clock
//    cycles. Each cycle it adds one bit position, starting at the LSB. The
//    upstream requester uses a start pulse and sees busy while the add runs.
//    A one-cycle done strobe marks the result as ready.
//
// Parameters:
//    WIDTH      operand/result width in bits, 1..32
//
// Ports:
//    clk        single clock, rising edge
//    rst        synchronous active-high reset
//    start      request pulse; accepted in IDLE or DONE
//    a, b       operands, captured on an accepted start
//    carry_in   initial carry, captured on an accepted start
//    busy       high while bits are being processed
//    done       one-cycle completion strobe
//    result     sum; held from done until the next accepted start
//    carry_out  final carry; valid with result
//    overflow   signed overflow (only with SERIAL_ADD_OVERFLOW_EN)
//
// Optional feature macro:
//    SERIAL_ADD_OVERFLOW_EN  adds the overflow output and its register
// ---------------------------------------------------------------------------

// One-bit full adder slice that the controller sequences.
module full_adder (
    input  logic left,
    input  logic right,
    input  logic past_carry,
    output logic sum,
    output logic carry
);
    assign sum   = left ^ right ^ past_carry;
    assign carry = (left & right) | (past_carry & (left ^ right));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // A 1-bit counter is still needed when WIDTH is 1, so the width never drops to zero.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_resultNext;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             r_overflow;
`endif

    full_adder u_fa (
        .left       (r_a[0]),
        .right      (r_b[0]),
        .past_carry (r_carry),
        .sum        (w_sum),
        .carry      (w_cout)
    );

    assign w_last = (r_count == CW'(WIDTH - 1));

    // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 has
    // reached position 0. When WIDTH is 1 there is nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_res1
            assign w_resultNext = w_sum;
        end else begin : g_resN
            assign w_resultNext = {w_sum, r_result[WIDTH-1:1]};
        end
    endgenerate

    // State register. A reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode. DONE accepts a start exactly as IDLE
    // does, which allows back-to-back requests.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath. Operands and carry load on an accepted start and shift while
    // in RUN. Outside RUN everything holds, so result and carry_out stay
    // stable after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_carry  <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            r_overflow <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_carry  <= w_cout;
            r_count  <= r_count + CW'(1);
            r_result <= w_resultNext;
`ifdef SERIAL_ADD_OVERFLOW_EN
            // On the last bit, r_carry is the carry into the MSB.
            if (w_last) begin
                r_overflow <= r_carry ^ w_cout;
            end
`endif
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;
`ifdef SERIAL_ADD_OVERFLOW_EN
    assign overflow  = r_overflow;
`endif

endmodule
